// File: rtl/io_uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : io_uart_pkg
// Brief    : Shared register offsets, STATUS bit positions and FSM encoding.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package io_uart_pkg;

    localparam logic [5:0] c_off_data   = 6'd0;
    localparam logic [5:0] c_off_status = 6'd1;

    localparam int c_bit_tx_full   = 0;
    localparam int c_bit_tx_empty  = 1;
    localparam int c_bit_rx_valid  = 2;
    localparam int c_bit_rx_ovr    = 3;
    localparam int c_bit_frame_err = 4;
    localparam int c_bit_tx_ovf    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/io_uart_fifo.sv
//------------------------------------------------------------------------------
// Module   : io_uart_fifo
// Brief    : Small synchronous FIFO; a push while full is accepted if a pop
//            happens in the same cycle. DEPTH must be a power of two.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module io_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_uart.sv
//------------------------------------------------------------------------------
// Module   : io_uart
// Brief    : AVR I/O-mapped 8N1 UART with DATA/STATUS registers and 4-deep TX FIFO.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module io_uart
    import io_uart_pkg::*;
#(
    parameter logic [5:0] BASE_ADDR = 6'h08,
    parameter int         CLK_DIV   = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] io_a,
    input  logic [7:0] io_do,
    output logic [7:0] io_di,
    input  logic       io_re,
    input  logic       io_we,
    output logic       txd,
    input  logic       rxd
);

    localparam logic [15:0] c_div_last  = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_half_last = 16'(CLK_DIV / 2 - 1);

    logic        w_hit_data, w_hit_stat, w_wr_data, w_rd_data, w_rd_stat;
    logic        w_tx_pop, w_tx_tick, w_tx_drop, w_tx_full, w_tx_empty;
    logic        w_fifo_full, w_fifo_empty;
    logic [7:0]  w_fifo_dout;
    logic [2:0]  w_fifo_count;
    logic [7:0]  w_status;

    uart_state_t r_tx_state;
    logic [15:0] r_tx_timer;
    logic [2:0]  r_tx_idx;
    logic [7:0]  r_tx_shift;
    logic        r_txd;

    uart_state_t r_rx_state;
    logic [15:0] r_rx_timer;
    logic [2:0]  r_rx_idx;
    logic [7:0]  r_rx_shift;
    logic [1:0]  r_rx_sync;
    logic        r_rx_prev;
    logic        w_rx, w_rx_tick, w_rx_done;

    logic [7:0]  r_rx_byte;
    logic        r_rx_valid, r_rx_ovr, r_frame_err, r_tx_ovf;

    assign w_hit_data = (io_a == BASE_ADDR + c_off_data);
    assign w_hit_stat = (io_a == BASE_ADDR + c_off_status);
    assign w_wr_data  = io_we && w_hit_data;
    assign w_rd_data  = io_re && w_hit_data;
    assign w_rd_stat  = io_re && w_hit_stat;

    io_uart_fifo #(.DEPTH(4), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_wr_data),
        .din   (io_do),
        .pop   (w_tx_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign w_tx_tick  = (r_tx_timer == c_div_last);
    assign w_tx_pop   = !w_fifo_empty &&
                        ((r_tx_state == ST_IDLE) || ((r_tx_state == ST_STOP) && w_tx_tick));
    assign w_tx_drop  = w_wr_data && w_fifo_full && !w_tx_pop;
    assign w_tx_full  = (w_fifo_count == 3'd4);
    assign w_tx_empty = w_fifo_empty && (r_tx_state == ST_IDLE);
    assign txd        = r_txd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_timer <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_timer <= (w_tx_tick || r_tx_state == ST_IDLE) ? 16'd0 : r_tx_timer + 16'd1;
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_state <= ST_START;
                        r_tx_shift <= w_fifo_dout;
                        r_txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tx_tick) begin
                        r_tx_state <= ST_DATA;
                        r_tx_idx   <= 3'd0;
                        r_txd      <= r_tx_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_tx_tick) begin
                        if (r_tx_idx == 3'd7) begin
                            r_tx_state <= ST_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_idx   <= r_tx_idx + 3'd1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_txd      <= r_tx_shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tx_tick) begin
                        // Chain straight into the next frame so queued bytes leave without gaps.
                        if (w_tx_pop) begin
                            r_tx_state <= ST_START;
                            r_tx_shift <= w_fifo_dout;
                            r_txd      <= 1'b0;
                        end else begin
                            r_tx_state <= ST_IDLE;
                        end
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    assign w_rx      = r_rx_sync[1];
    assign w_rx_tick = (r_rx_timer == c_div_last);
    assign w_rx_done = (r_rx_state == ST_STOP) && w_rx_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_timer <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rxd};
            r_rx_prev <= w_rx;
            case (r_rx_state)
                ST_IDLE: begin
                    r_rx_timer <= 16'd0;
                    if (r_rx_prev && !w_rx) begin
                        r_rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Mid-start sample; a line already back high was only a glitch.
                    if (r_rx_timer == c_half_last) begin
                        r_rx_timer <= 16'd0;
                        r_rx_idx   <= 3'd0;
                        r_rx_state <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_timer <= r_rx_timer + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_timer <= 16'd0;
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        r_rx_idx   <= r_rx_idx + 3'd1;
                        if (r_rx_idx == 3'd7) begin
                            r_rx_state <= ST_STOP;
                        end
                    end else begin
                        r_rx_timer <= r_rx_timer + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_timer <= 16'd0;
                        r_rx_state <= ST_IDLE;
                    end else begin
                        r_rx_timer <= r_rx_timer + 16'd1;
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_byte   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_ovr    <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx_ovf    <= 1'b0;
        end else begin
            // A DATA read in the completion cycle frees the slot for the new byte.
            if (w_rx_done && (!r_rx_valid || w_rd_data)) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end

            if (w_rx_done && r_rx_valid && !w_rd_data) begin
                r_rx_ovr <= 1'b1;
            end else if (w_rd_stat) begin
                r_rx_ovr <= 1'b0;
            end

            if (w_rx_done && !w_rx) begin
                r_frame_err <= 1'b1;
            end else if (w_rd_stat) begin
                r_frame_err <= 1'b0;
            end

            if (w_tx_drop) begin
                r_tx_ovf <= 1'b1;
            end else if (w_rd_stat) begin
                r_tx_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                  = '0;
        w_status[c_bit_tx_full]   = w_tx_full;
        w_status[c_bit_tx_empty]  = w_tx_empty;
        w_status[c_bit_rx_valid]  = r_rx_valid;
        w_status[c_bit_rx_ovr]    = r_rx_ovr;
        w_status[c_bit_frame_err] = r_frame_err;
        w_status[c_bit_tx_ovf]    = r_tx_ovf;
    end

    always_comb begin
        io_di = '0;
        if (w_rd_data) begin
            io_di = r_rx_byte;
        end else if (w_rd_stat) begin
            io_di = w_status;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_io_uart.sv
//------------------------------------------------------------------------------
// Module   : tb_io_uart
// Brief    : Directed self-checking bench for io_uart with CLK_DIV=16.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_uart;

    localparam logic [5:0] c_data = 6'h08;
    localparam logic [5:0] c_stat = 6'h09;
    localparam int         c_div  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] io_a;
    logic [7:0] io_do;
    logic [7:0] io_di;
    logic       io_re;
    logic       io_we;
    logic       txd;
    logic       rxd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] mon_byte [$];
    logic       mon_stop [$];
    int         mon_start[$];
    int         mon_st;
    logic [7:0] mon_b;

    io_uart #(.BASE_ADDR(6'h08), .CLK_DIV(c_div)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_a  (io_a),
        .io_do (io_do),
        .io_di (io_di),
        .io_re (io_re),
        .io_we (io_we),
        .txd   (txd),
        .rxd   (rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Background serial decoder for the TX line (samples at bit centres).
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && txd === 1'b0) begin
                mon_st = cyc;
                repeat (8) @(posedge clk);
                #1;
                for (int k = 0; k < 8; k++) begin
                    repeat (16) @(posedge clk);
                    #1;
                    mon_b[k] = txd;
                end
                repeat (16) @(posedge clk);
                #1;
                mon_byte.push_back(mon_b);
                mon_stop.push_back(txd);
                mon_start.push_back(mon_st);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Bus tasks: entered and left #1 after a rising edge.
    task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
        io_a  = a;
        io_do = d;
        io_we = 1'b1;
        @(posedge clk); #1;
        io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [7:0] d);
        io_a  = a;
        io_re = 1'b1;
        #1;
        d = io_di;
        @(posedge clk); #1;
        io_re = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (c_div) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0; io_a = '0; io_do = '0; io_re = 1'b0; io_we = 1'b0; rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", txd); end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL reset_status_in_reset: got %h expected 02", d); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL reset_status: got %h expected 02", d); end
        bus_read(c_data, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", d); end
    endtask

    task automatic test_addr();
        logic [7:0] d;
        bus_read(6'h0A, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL unmapped_read: got %h expected 00", d); end
        bus_write(c_stat, 8'hFF);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL status_write_txd: got %b expected 1", txd); end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL status_write_noeffect: got %h expected 02", d); end
    endtask

    task automatic test_tx_single();
        logic [9:0] fr;
        logic [7:0] d;
        int         bad;
        fr = {1'b1, 8'hA5, 1'b0};
        bus_write(c_data, 8'hA5);
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL tx_latency: got txd=%b expected 1 before start", txd); end
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < c_div; c++) begin
                @(posedge clk); #1;
                if (txd !== fr[b]) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL tx_bit%0d: got %0d wrong cycles expected level %b for all 16", b, bad, fr[b]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL tx_idle_after: got %b expected 1", txd); end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL tx_empty_after: got %h expected 02", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [7:0] exp_b [5];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        mon_byte.delete(); mon_stop.delete(); mon_start.delete();
        for (int i = 0; i < 5; i++) bus_write(c_data, exp_b[i]);
        bus_write(c_data, 8'h66);
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h21) begin failures++; $display("FAIL b2b_status_full_ovf: got %h expected 21", d); end
        repeat (840) @(posedge clk);
        #1;
        checks++;
        if (mon_byte.size() != 5) begin
            failures++;
            $display("FAIL b2b_frame_count: got %0d expected 5", mon_byte.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (mon_byte[i] !== exp_b[i] || mon_stop[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_frame%0d: got %h stop %b expected %h stop 1", i, mon_byte[i], mon_stop[i], exp_b[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mon_start[i+1] - mon_start[i] != 10 * c_div) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: got %0d cycles expected %0d", i, mon_start[i+1] - mon_start[i], 10 * c_div);
                end
            end
        end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL b2b_status_end: got %h expected 02", d); end
    endtask

    task automatic test_rx();
        logic [7:0] d;
        send_rx(8'h3C, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h06) begin failures++; $display("FAIL rx_valid_set: got %h expected 06", d); end
        bus_read(c_data, d);
        checks++;
        if (d !== 8'h3C) begin failures++; $display("FAIL rx_data: got %h expected 3c", d); end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL rx_valid_clear: got %h expected 02", d); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        send_rx(8'h11, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        send_rx(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h0E) begin failures++; $display("FAIL ovr_status: got %h expected 0e", d); end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h06) begin failures++; $display("FAIL ovr_cleared: got %h expected 06", d); end
        bus_read(c_data, d);
        checks++;
        if (d !== 8'h11) begin failures++; $display("FAIL ovr_first_kept: got %h expected 11", d); end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL ovr_end: got %h expected 02", d); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        send_rx(8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h16) begin failures++; $display("FAIL ferr_status: got %h expected 16", d); end
        bus_read(c_data, d);
        checks++;
        if (d !== 8'h5A) begin failures++; $display("FAIL ferr_data: got %h expected 5a", d); end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL ferr_cleared: got %h expected 02", d); end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        repeat (20) @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (c_div / 4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL glitch_no_byte: got %h expected 02", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        int         lows;
        bus_write(c_data, 8'h96);
        bus_write(c_data, 8'h5A);
        bus_write(c_data, 8'hC3);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b0 && txd !== 1'b1) begin failures++; $display("FAIL rst_pre_txd: got %b expected 0 or 1", txd); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL rst_async_txd: got %b expected 1", txd); end
        @(posedge clk); #1;
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL rst_fifo_empty: got %h expected 02", d); end
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin failures++; $display("FAIL rst_no_resume: got %0d low cycles expected 0", lows); end
        bus_read(c_stat, d);
        checks++;
        if (d !== 8'h02) begin failures++; $display("FAIL rst_status_after: got %h expected 02", d); end
    endtask

    initial begin
        test_reset();
        test_addr();
        test_tx_single();
        repeat (20) @(posedge clk);
        #1;
        test_back_to_back();
        test_rx();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
